tiny16_mem_arbiter: RTL

Shares the single-port, synchronous-read program/data RAM of the tiny16 system between two requesters: port 0 (CPU fetch/load/store) and port 1 (loader/DMA). It serialises accesses, inserts programmable wait states, and returns a one-cycle acknowledge with read data. It sits between the tiny16 core, the loader, and the RAM macro.

---
 rtl/tiny16_pkg.sv | 17 +
 rtl/tiny16_rr_pick.sv | 22 ++
 rtl/tiny16_mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tiny16_pkg.sv
// tiny16 shared definitions: word width, port id and
// memory arbiter FSM states.
package tiny16_pkg;

    localparam int WORD_W = 16;

    typedef logic port_id_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WAIT,
        S_ACK
    } arb_state_t;

endpackage

// File: rtl/tiny16_rr_pick.sv
// Two-way round-robin picker: on contention the port
// not granted last time wins.
module tiny16_rr_pick
    import tiny16_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_gnt,
    output logic       gnt_valid,
    output port_id_t   gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        unique case (1'b1)
            (req == 2'b11): gnt_id = ~last_gnt;
            (req == 2'b10): gnt_id = 1'b1;
            default:        gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/tiny16_mem_arbiter.sv
// Serialises CPU and loader accesses onto the single-port
// tiny16 RAM with programmable wait states.
module tiny16_mem_arbiter
    import tiny16_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [WORD_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state;
    port_id_t          last_gnt;
    port_id_t          gnt_id;
    port_id_t          cur_id;
    logic              gnt_valid;
    logic              cur_we;
    logic [3:0]        cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;

    tiny16_rr_pick u_pick (
        .req       ({req1, req0}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (gnt_id) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            last_gnt  <= 1'b1;
            cur_id    <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        cur_id    <= gnt_id;
                        cur_we    <= sel_we;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!cur_we) begin
                        rdata <= mem_rdata;
                    end
                    cnt <= 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state <= S_WAIT;
                    end else begin
                        ack0  <= ~cur_id;
                        ack1  <= cur_id;
                        state <= S_ACK;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        ack0  <= ~cur_id;
                        ack1  <= cur_id;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    last_gnt <= cur_id;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
